alu_multiword_seq: RTL and testbench

- Sequencing master for the combinational n-bit ALU. Accepts a wide operation (SLICES x N bits) over a valid/ready request channel.
- Drives the ALU one N-bit slice per clock, chaining each slice's carry into the next slice's FlagIn.
- Returns the assembled result, final carry and global zero over a valid/ready response channel.
- Sits between the datapath controller and an external ALU instance. The ALU's ALUA/ALUB/ALUControl/ALUFlagIn/ALUResult/C/Z pins connect to this block's alu_* ports.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_multiword_seq.sv | 128 ++++++++++++
 tb/tb_alu_multiword_seq.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multiword ALU sequencer: ALU control codes,
// sequencer FSM states and the slice-index width helper.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SHL = 4'h8;
    localparam logic [3:0] ALU_SHR = 4'h9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_multiword_seq.sv
// Sequences a WIDTH-bit operation through an external N-bit combinational ALU,
// one slice per clock, chaining each slice's carry into the next FlagIn.
module alu_multiword_seq
    import alu_pkg::*;
#(
    parameter int N      = 4,
    parameter int SLICES = 4,
    localparam int WIDTH = N * SLICES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_control,
    input  logic             req_flag_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_c,
    output logic             rsp_z,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_control,
    output logic             alu_flag_in,
    input  logic [N-1:0]     alu_result,
    input  logic             alu_c,
    input  logic             alu_z
);

    localparam int             KW     = clog2(SLICES);
    localparam logic [KW-1:0]  K_LAST = KW'(SLICES - 1);

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    s;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic [3:0]       ctrl_q;
    logic             fin_q, carry_q, c_q, z_q;
    logic             accept, last, shift_op;

    // The global zero is derived from the assembled result, so the ALU's own Z is not needed.
    logic unused_alu_z;
    assign unused_alu_z = alu_z;

    assign req_ready = (state_q == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign last      = (state_q == RUN) && (k_q == K_LAST);
    assign shift_op  = (ctrl_q == ALU_SHL) || (ctrl_q == ALU_SHR);
    // Right shifts walk MSW first so the carry carries bits downward.
    assign s         = (ctrl_q == ALU_SHR) ? (K_LAST - k_q) : k_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (k_q == K_LAST) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid   = (state_q == DONE);
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        alu_flag_in = 1'b0;
        if (state_q == RUN) begin
            for (int i = 0; i < SLICES; i++) begin
                if (s == KW'(i)) begin
                    alu_a = a_q[i*N +: N];
                    alu_b = shift_op ? b_q[N-1:0] : b_q[i*N +: N];
                end
            end
            alu_control = ctrl_q;
            alu_flag_in = (k_q == '0) ? fin_q : carry_q;
        end
    end

    always_comb begin
        res_d = res_q;
        for (int i = 0; i < SLICES; i++) begin
            if (s == KW'(i)) res_d[i*N +: N] = alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            fin_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else if (accept) begin
            a_q     <= req_a;
            b_q     <= req_b;
            ctrl_q  <= req_control;
            fin_q   <= req_flag_in;
            carry_q <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
        end else if (state_q == RUN) begin
            res_q   <= res_d;
            carry_q <= alu_c;
            k_q     <= last ? '0 : k_q + 1'b1;
            if (last) begin
                c_q <= alu_c;
                z_q <= ~|res_d;
            end
        end
    end

    assign rsp_result = res_q;
    assign rsp_c      = c_q;
    assign rsp_z      = z_q;

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Directed bench for alu_multiword_seq (N=4, SLICES=2) with a behavioural
// n-bit ALU, an expected-response queue and a decoupled response monitor.
module tb_alu_multiword_seq;

    localparam int N      = 4;
    localparam int SLICES = 2;
    localparam int W      = N * SLICES;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [3:0]   req_control;
    logic         req_flag_in;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_c;
    logic         rsp_z;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_control;
    logic         alu_flag_in;
    logic [N-1:0] alu_result;
    logic         alu_c;
    logic         alu_z;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected entry layout: {result, c, z}
    logic [W+1:0] exp_q[$];

    alu_multiword_seq #(.N(N), .SLICES(SLICES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_control (req_control),
        .req_flag_in (req_flag_in),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_c       (rsp_c),
        .rsp_z       (rsp_z),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_flag_in (alu_flag_in),
        .alu_result  (alu_result),
        .alu_c       (alu_c),
        .alu_z       (alu_z)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- behavioural n-bit ALU ----------------
    always_comb begin
        logic [N-1:0] r;
        logic         c;
        r = '0;
        c = 1'b0;
        case (alu_control)
            4'h0: {c, r} = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_flag_in};
            4'h1: {c, r} = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, alu_flag_in};
            4'h2: r = alu_a & alu_b;
            4'h3: r = alu_a | alu_b;
            4'h4: r = alu_a ^ alu_b;
            4'h8: begin
                r = alu_a;
                for (int i = 0; i < 15; i++) begin
                    if (i < int'(alu_b)) begin
                        c = r[N-1];
                        r = {r[N-2:0], alu_flag_in};
                    end
                end
            end
            4'h9: begin
                r = alu_a;
                for (int i = 0; i < 15; i++) begin
                    if (i < int'(alu_b)) begin
                        c = r[0];
                        r = {alu_flag_in, r[N-1:1]};
                    end
                end
            end
            default: r = '0;
        endcase
        alu_result = r;
        alu_c      = c;
        alu_z      = (r == '0);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake happens at the next edge whenever both are high here.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got result %0h with no request pending", rsp_result);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                check("rsp_result", 32'(rsp_result), 32'(e[W+1:2]));
                check("rsp_c", 32'(rsp_c), 32'(e[1]));
                check("rsp_z", 32'(rsp_z), 32'(e[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept(output int acc);
        bit got;
        bit r;
        got = 1'b0;
        acc = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk);
            #1;
            if (r) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        check("accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [3:0] ctrl, input logic fin);
        req_a       = a;
        req_b       = b;
        req_control = ctrl;
        req_flag_in = fin;
        req_valid   = 1'b1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] ctrl, input logic fin, input bit push,
                         input logic [W-1:0] er, input logic ec, input logic ez,
                         output int acc);
        @(posedge clk);
        #1;
        drive_req(a, b, ctrl, fin);
        wait_accept(acc);
        if (push) exp_q.push_back({er, ec, ez});
        req_valid   = 1'b0;
        req_a       = ~a;
        req_b       = ~b;
        req_control = 4'h3;
        req_flag_in = ~fin;
    endtask

    task automatic wait_rsp(output int seen);
        bit got;
        got  = 1'b0;
        seen = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got  = 1'b1;
                seen = cyc;
            end
        end
        check("rsp_timeout", 32'(got), 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!rsp_valid && exp_q.size() == 0) done = 1'b1;
        end
        check("drain_timeout", 32'(done), 32'd1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int acc, acc2, seen;
        int bad;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_a       = '0;
        req_b       = '0;
        req_control = '0;
        req_flag_in = 1'b0;
        rsp_ready   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_c", 32'(rsp_c), 32'd0);
        check("rst_rsp_z", 32'(rsp_z), 32'd0);
        check("rst_alu_bus", 32'({alu_a, alu_b, alu_control, alu_flag_in}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Left shift chain with latency measurement
        issue(8'h66, 8'h02, 4'h8, 1'b0, 1'b1, 8'hB8, 1'b1, 1'b0, acc);
        wait_rsp(seen);
        check("shl_latency", 32'(seen - acc), 32'd2);
        drain();

        // Right shift, MSW first, flag chaining
        issue(8'h66, 8'h02, 4'h9, 1'b0, 1'b1, 8'h1D, 1'b1, 1'b0, acc);
        @(negedge clk);
        check("shr_s1_alu_a", 32'(alu_a), 32'h6);
        check("shr_s1_alu_b", 32'(alu_b), 32'h2);
        check("shr_s1_ctrl", 32'(alu_control), 32'h9);
        check("shr_s1_flag", 32'(alu_flag_in), 32'd0);
        @(negedge clk);
        check("shr_s0_alu_a", 32'(alu_a), 32'h6);
        check("shr_s0_flag", 32'(alu_flag_in), 32'd1);
        drain();
        check("idle_alu_bus", 32'({alu_a, alu_b, alu_control, alu_flag_in}), 32'd0);

        // Zero flag
        issue(8'h00, 8'h00, 4'h8, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, acc);
        drain();

        // Add with carry across the slice boundary: 9F + 71 = 110
        issue(8'h9F, 8'h71, 4'h0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, acc);
        drain();

        // Backpressure: hold rsp_ready low, offer a competing request
        rsp_ready = 1'b0;
        issue(8'h66, 8'h02, 4'h8, 1'b0, 1'b1, 8'hB8, 1'b1, 1'b0, acc);
        wait_rsp(seen);
        drive_req(8'h12, 8'h34, 4'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_result", 32'(rsp_result), 32'hB8);
            check("bp_rsp_c", 32'(rsp_c), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_after_req_ready", 32'(req_ready), 32'd1);
        check("bp_after_rsp_valid", 32'(rsp_valid), 32'd0);
        drain();

        // Reset during slice 1 aborts the operation
        issue(8'h9F, 8'h71, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_result", 32'(rsp_result), 32'd0);
        check("mid_rst_rsp_c", 32'(rsp_c), 32'd0);
        check("mid_rst_alu_bus", 32'({alu_a, alu_b, alu_control, alu_flag_in}), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check("no_stale_rsp", 32'(bad), 32'd0);
        issue(8'h9F, 8'h71, 4'h0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, acc);
        drain();

        // Back-to-back with req_valid held high
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        drive_req(8'h66, 8'h02, 4'h8, 1'b0);
        wait_accept(acc);
        exp_q.push_back({8'hB8, 1'b1, 1'b0});
        drive_req(8'h66, 8'h02, 4'h9, 1'b0);
        wait_accept(acc2);
        exp_q.push_back({8'h1D, 1'b1, 1'b0});
        req_valid = 1'b0;
        check("b2b_accept_gap", 32'(acc2 - acc), 32'(SLICES + 2));
        drain();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
